// File: rtl/ccdiv_seq_pkg.sv
// ccdiv_seq_pkg: shared widths and FSM state encoding for the sequential
// complex/complex divider (ccdiv_seq) and its restoring-division step.
package ccdiv_seq_pkg;

    // Operand/result width, two's complement
    localparam int TOTAL_WIDTH = 16;
    // Fractional bits; 1.0 == 2**FRAC_WIDTH
    localparam int FRAC_WIDTH  = 8;
    // Width of a full operand product
    localparam int MULT_WIDTH  = 2 * TOTAL_WIDTH;

    // Divider control states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MULT  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DIV   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/ccdiv_seq_udiv_step.sv
// ccdiv_seq_udiv_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, subtracts the
// divisor when it fits and reports the resulting quotient bit.
module ccdiv_seq_udiv_step #(
    parameter int RW = 33,   // remainder width
    parameter int DW = 32    // divisor width (DW < RW + 1)
) (
    input  logic [RW-1:0] rem_i,
    input  logic [DW-1:0] div_i,
    input  logic          bit_i,
    output logic [RW-1:0] rem_o,
    output logic          q_o
);

    logic [RW:0] shifted;
    logic [RW:0] div_ext;

    // Trial subtraction of the divisor from the shifted partial remainder
    always_comb begin
        shifted = {rem_i, bit_i};
        div_ext = (RW+1)'(div_i);
        q_o     = (shifted >= div_ext);
        rem_o   = q_o ? RW'(shifted - div_ext) : RW'(shifted);
    end

endmodule

// File: rtl/ccdiv_seq.sv
// ccdiv_seq: sequential complex/complex divider, q = a*conj(b) / |b|^2,
// signed fixed point (W bits, F fractional). One division in flight,
// valid/ready on both sides, saturating, truncating toward zero.
// Optional build macro CCDIV_ROUND_EN: one extra quotient bit and
// round-half-away-from-zero of the magnitude (latency grows by one cycle).
module ccdiv_seq
    import ccdiv_seq_pkg::*;
#(
    parameter int W = TOTAL_WIDTH,
    parameter int F = FRAC_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] ar,
    input  logic signed [W-1:0] ai,
    input  logic signed [W-1:0] br,
    input  logic signed [W-1:0] bi,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] qr,
    output logic signed [W-1:0] qi,
    output logic                dz,
    output logic                ovf
);

    localparam int NW = 2 * W;      // numerator magnitude / denominator width
    localparam int RW = 2 * W + 1;  // partial remainder width
`ifdef CCDIV_ROUND_EN
    localparam int QW = W + 1;      // raw quotient carries one rounding bit
`else
    localparam int QW = W;
`endif
    localparam int CW = $clog2(QW);
    localparam logic [CW-1:0] LAST_IT = CW'(QW - 1);
    localparam logic [W:0]    LIM_POS = (W+1)'((1 << (W-1)) - 1);
    localparam logic [W:0]    LIM_NEG = (W+1)'(1 << (W-1));
    localparam logic [W-1:0]  Q_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  Q_MIN   = {1'b1, {(W-1){1'b0}}};

    // Control and registered outputs
    state_t                state_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic signed [W-1:0]   qr_q;
    logic signed [W-1:0]   qi_q;
    logic                  dz_q;
    logic                  ovf_q;
    logic [CW-1:0]         cnt_q;

    // Datapath registers (no reset: only meaningful once the FSM uses them)
    logic signed [W-1:0]   ar_q, ai_q, br_q, bi_q;
    logic [NW-1:0]         nr_mag_q, ni_mag_q, den_q;
    logic                  nr_neg_q, ni_neg_q;
    logic                  ovr_q, ovi_q, dzf_q;
    logic [RW-1:0]         rem_r_q, rem_i_q;
    logic [QW-1:0]         low_r_q, low_i_q;
    logic [QW-1:0]         quo_r_q, quo_i_q;

    // Combinational intermediates
    logic signed [NW-1:0]  p_rr, p_ii, p_ir, p_ri, p_brbr, p_bibi;
    logic signed [NW:0]    nr_d, ni_d;
    logic [NW-1:0]         nr_mag_d, ni_mag_d, den_d;
    logic [3*W-1:0]        den_sh;
    logic                  ovr_d, ovi_d;
    logic [RW-1:0]         rem_r_d, rem_i_d;
    logic                  qb_r, qb_i;
    logic [QW-1:0]         qfin_r, qfin_i;
    logic [W:0]            fr_d, fi_d;

    // Turn a raw unsigned quotient into a signed, saturated result.
    // Returns {saturated, value}.
    function automatic logic [W:0] fmt_q(input logic [QW-1:0] raw,
                                         input logic          neg,
                                         input logic          ovflag);
        logic [W:0]   u;
        logic [W-1:0] res;
        logic         sat;
`ifdef CCDIV_ROUND_EN
        // Extra LSB is the half bit: add it to round half away from zero
        u = (W+1)'(raw >> 1) + (W+1)'(raw[0]);
`else
        u = (W+1)'(raw);
`endif
        if (neg) begin
            if (ovflag || (u > LIM_NEG)) begin
                res = Q_MIN;
                sat = 1'b1;
            end else begin
                res = W'(-u);
                sat = 1'b0;
            end
        end else begin
            if (ovflag || (u > LIM_POS)) begin
                res = Q_MAX;
                sat = 1'b1;
            end else begin
                res = W'(u);
                sat = 1'b0;
            end
        end
        return {sat, res};
    endfunction

    // Numerators a*conj(b), denominator |b|^2 and their magnitudes
    always_comb begin
        p_rr     = NW'(ar_q) * NW'(br_q);
        p_ii     = NW'(ai_q) * NW'(bi_q);
        p_ir     = NW'(ai_q) * NW'(br_q);
        p_ri     = NW'(ar_q) * NW'(bi_q);
        p_brbr   = NW'(br_q) * NW'(br_q);
        p_bibi   = NW'(bi_q) * NW'(bi_q);
        nr_d     = (NW+1)'(p_rr) + (NW+1)'(p_ii);
        ni_d     = (NW+1)'(p_ir) - (NW+1)'(p_ri);
        den_d    = $unsigned(p_brbr) + $unsigned(p_bibi);
        nr_mag_d = nr_d[NW] ? NW'(-nr_d) : NW'(nr_d);
        ni_mag_d = ni_d[NW] ? NW'(-ni_d) : NW'(ni_d);
    end

    // Quotient would need more than QW bits when (|n| << F) >= (den << W)
    always_comb begin
        den_sh = (3*W)'(den_q) << W;
        ovr_d  = (((3*W)'(nr_mag_q)) << F) >= den_sh;
        ovi_d  = (((3*W)'(ni_mag_q)) << F) >= den_sh;
    end

    ccdiv_seq_udiv_step #(.RW(RW), .DW(NW)) u_step_r (
        .rem_i (rem_r_q),
        .div_i (den_q),
        .bit_i (low_r_q[QW-1]),
        .rem_o (rem_r_d),
        .q_o   (qb_r)
    );

    ccdiv_seq_udiv_step #(.RW(RW), .DW(NW)) u_step_i (
        .rem_i (rem_i_q),
        .div_i (den_q),
        .bit_i (low_i_q[QW-1]),
        .rem_o (rem_i_d),
        .q_o   (qb_i)
    );

    // Quotient including the bit produced this cycle, and its final format
    always_comb begin
        qfin_r = QW'({quo_r_q, qb_r});
        qfin_i = QW'({quo_i_q, qb_i});
        fr_d   = fmt_q(qfin_r, nr_neg_q, ovr_q);
        fi_d   = fmt_q(qfin_i, ni_neg_q, ovi_q);
    end

    // Datapath: operand capture, products, division setup and iteration
    always_ff @(posedge clk) begin
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    ar_q <= ar;
                    ai_q <= ai;
                    br_q <= br;
                    bi_q <= bi;
                end
            end
            ST_MULT: begin
                nr_mag_q <= nr_mag_d;
                ni_mag_q <= ni_mag_d;
                nr_neg_q <= nr_d[NW];
                ni_neg_q <= ni_d[NW];
                den_q    <= den_d;
            end
            ST_CHECK: begin
                dzf_q   <= (den_q == '0);
                ovr_q   <= ovr_d;
                ovi_q   <= ovi_d;
                // Dividend is |n| << F: the bits above W seed the remainder,
                // the low W bits (plus a zero rounding bit) are shifted in.
                rem_r_q <= RW'(nr_mag_q >> (W - F));
                rem_i_q <= RW'(ni_mag_q >> (W - F));
                low_r_q <= QW'(W'({nr_mag_q, {F{1'b0}}})) << (QW - W);
                low_i_q <= QW'(W'({ni_mag_q, {F{1'b0}}})) << (QW - W);
            end
            ST_DIV: begin
                rem_r_q <= rem_r_d;
                rem_i_q <= rem_i_d;
                quo_r_q <= qfin_r;
                quo_i_q <= qfin_i;
                low_r_q <= low_r_q << 1;
                low_i_q <= low_i_q << 1;
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            qr_q        <= '0;
            qi_q        <= '0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= ST_MULT;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_MULT: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    state_q <= ST_DIV;
                    cnt_q   <= '0;
                end
                ST_DIV: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_IT) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        dz_q        <= dzf_q;
                        if (dzf_q) begin
                            qr_q  <= '0;
                            qi_q  <= '0;
                            ovf_q <= 1'b0;
                        end else begin
                            qr_q  <= fr_d[W-1:0];
                            qi_q  <= fi_d[W-1:0];
                            ovf_q <= fr_d[W] | fi_d[W];
                        end
                    end
                end
                ST_DONE: begin
                    // New operands are never taken here; IDLE comes first
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign qr        = qr_q;
    assign qi        = qi_q;
    assign dz        = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_ccdiv_seq.sv
// tb_ccdiv_seq: self-checking bench for ccdiv_seq (W=16, F=8).
module tb_ccdiv_seq;

    localparam int W = 16;
    localparam int F = 8;
`ifdef CCDIV_ROUND_EN
    localparam int LAT = W + 4;
`else
    localparam int LAT = W + 3;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] qr, qi;
    logic                dz, ovf;

    always #5 clk = ~clk;

    ccdiv_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ar        (ar),
        .ai        (ai),
        .br        (br),
        .bi        (bi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .qr        (qr),
        .qi        (qi),
        .dz        (dz),
        .ovf       (ovf)
    );

    typedef struct {
        logic signed [W-1:0] qr;
        logic signed [W-1:0] qi;
        logic                dz;
        logic                ovf;
    } exp_t;

    typedef struct {
        string               name;
        logic signed [W-1:0] ar, ai, br, bi;
        exp_t                e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: exact integer arithmetic on the quotient definition
    function automatic void comp(input longint n, input longint den,
                                 output logic signed [W-1:0] q, output logic sat);
        longint mag, u, lim;
        mag = (n < 0) ? -n : n;
`ifdef CCDIV_ROUND_EN
        u = (2 * (mag * 256) + den) / (2 * den);
`else
        u = (mag * 256) / den;
`endif
        lim = (n < 0) ? 32768 : 32767;
        if ((mag * 256) >= (den * 65536) || u > lim) begin
            sat = 1'b1;
            q   = (n < 0) ? W'(-lim) : W'(lim);
        end else begin
            sat = 1'b0;
            q   = (n < 0) ? W'(-u) : W'(u);
        end
    endfunction

    function automatic exp_t model(input logic signed [W-1:0] a_r, a_i, b_r, b_i);
        exp_t   e;
        longint nr, ni, den;
        logic   s1, s2;
        nr  = longint'(a_r) * longint'(b_r) + longint'(a_i) * longint'(b_i);
        ni  = longint'(a_i) * longint'(b_r) - longint'(a_r) * longint'(b_i);
        den = longint'(b_r) * longint'(b_r) + longint'(b_i) * longint'(b_i);
        if (den == 0) begin
            e.qr = '0; e.qi = '0; e.dz = 1'b1; e.ovf = 1'b0;
        end else begin
            comp(nr, den, e.qr, s1);
            comp(ni, den, e.qi, s2);
            e.dz  = 1'b0;
            e.ovf = s1 | s2;
        end
        return e;
    endfunction

    function automatic vec_t mk(input string name, input int a_r, a_i, b_r, b_i,
                                input int q_r, q_i, input logic d, o);
        vec_t v;
        v.name = name;
        v.ar = W'(a_r); v.ai = W'(a_i); v.br = W'(b_r); v.bi = W'(b_i);
        v.e.qr = W'(q_r); v.e.qi = W'(q_i); v.e.dz = d; v.e.ovf = o;
        return v;
    endfunction

    // Present one operation, check latency and result; optionally hold
    // out_ready low for 'hold' cycles while offering new operands.
    task automatic do_op(input vec_t v, input int hold);
        int   waitc;
        int   lat;
        exp_t e;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk({v.name, "_in_ready"}, in_ready, 1);
        ar = v.ar; ai = v.ai; br = v.br; bi = v.bi;
        in_valid = 1'b1;
        sb.push_back(v.e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < LAT + 20) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, lat, LAT);
        if (!out_valid) begin
            $display("FAIL %s_timeout actual=no_out_valid required=out_valid", v.name);
            failures++;
            checks++;
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({v.name, "_qr"},  qr,  e.qr);
        chk({v.name, "_qi"},  qi,  e.qi);
        chk({v.name, "_dz"},  dz,  e.dz);
        chk({v.name, "_ovf"}, ovf, e.ovf);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            ar = W'($urandom); ai = W'($urandom); br = W'($urandom); bi = W'($urandom);
            @(negedge clk);
            chk({v.name, "_hold_valid"}, out_valid, 1);
            chk({v.name, "_hold_qr"},    qr,        e.qr);
            chk({v.name, "_hold_qi"},    qi,        e.qi);
            chk({v.name, "_hold_ready"}, in_ready,  0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({v.name, "_retire_valid"}, out_valid, 0);
        chk({v.name, "_retire_ready"}, in_ready,  1);
    endtask

    initial begin
        int   nvec;
        int   stray;
        vec_t v;

        vecs[0]  = mk("basic",     512,   256,   256,   0,   512,    256, 1'b0, 1'b0);
        vecs[1]  = mk("conj",      256,     0,   256, 256,   128,   -128, 1'b0, 1'b0);
        vecs[2]  = mk("unit",        0,   256,     0, 256,   256,      0, 1'b0, 1'b0);
        vecs[3]  = mk("divzero",   100,  -100,     0,   0,     0,      0, 1'b1, 1'b0);
        vecs[4]  = mk("satpos",  32767,     0,     1,   0, 32767,      0, 1'b0, 1'b1);
        vecs[5]  = mk("satneg", -32768,     0,     1,   0, -32768,     0, 1'b0, 1'b1);
        vecs[6]  = mk("zeronum",     0,     0,   300,  -7,     0,      0, 1'b0, 1'b0);
        vecs[7]  = mk("third",       1,     0,     3,   0,    85,      0, 1'b0, 1'b0);
        vecs[8]  = mk("negthird",   -1,     0,     3,   0,   -85,      0, 1'b0, 1'b0);
        vecs[9]  = mk("negzero",    -1,     0, 32767,   0,     0,      0, 1'b0, 1'b0);
        vecs[10] = mk("minexact", -128,     0,     1,   0, -32768,     0, 1'b0, 1'b0);
        vecs[11] = mk("maxover",   128,     0,     1,   0, 32767,      0, 1'b0, 1'b1);
        for (int i = 12; i < 16; i++) begin
            v.name = $sformatf("rand%0d", i);
            if (i < 14) begin
                v.ar = W'(int'($urandom_range(0, 4000)) - 2000);
                v.ai = W'(int'($urandom_range(0, 4000)) - 2000);
                v.br = W'(int'($urandom_range(0, 4000)) - 2000);
                v.bi = W'(int'($urandom_range(0, 4000)) - 2000);
            end else begin
                v.ar = W'($urandom); v.ai = W'($urandom);
                v.br = W'($urandom); v.bi = W'($urandom);
            end
            v.e = model(v.ar, v.ai, v.br, v.bi);
            vecs[i] = v;
        end
        nvec = 16;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_in_ready",  in_ready,  1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_qr",        qr,        0);
        chk("reset_qi",        qi,        0);
        chk("reset_dz",        dz,        0);
        chk("reset_ovf",       ovf,       0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            do_op(vecs[i], 0);
        end

        // Backpressure with new operands offered in DONE and at retirement
        do_op(vecs[1], 10);

        // Reset in the middle of the division (iteration 5)
        ar = 16'sd512; ai = 16'sd256; br = 16'sd256; bi = 16'sd0;
        in_valid = 1'b1;
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        chk("midrst_busy", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready_after", in_ready,  1);
        chk("midrst_out_valid",      out_valid, 0);
        chk("midrst_qr",             qr,        0);
        chk("midrst_dz",             dz,        0);
        chk("midrst_ovf",            ovf,       0);
        stray = 0;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("midrst_stray_output", stray, 0);
        do_op(vecs[2], 0);
        do_op(vecs[8], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
